spi_slave_cs: RTL

SPI_SLAVE_CS -- requirements
Module: spi_slave_cs

---
 rtl/spi_slave_cs_if.sv | 28 ++
 rtl/spi_slave_cs.sv | 139 +++++++++++++
 2 files changed

// File: rtl/spi_slave_cs_if.sv
// SPI slave bus bundle: serial pins on the master side plus the byte-wide
// TX/RX handshake seen by the local logic.
interface spi_slave_cs_if #(
  parameter int MAX_BYTES_PER_CS = 10
);
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);

  logic          i_SPCK;
  logic          i_CS_n;
  logic          i_MOSI;
  logic          o_MISO;
  logic [7:0]    i_TX_Byte;
  logic          i_TX_En;
  logic          o_TX_Ready;
  logic [7:0]    o_RX_Byte;
  logic          o_RX_En;
  logic [CW-1:0] o_RX_Count;

  modport slave (
    input  i_SPCK, i_CS_n, i_MOSI, i_TX_Byte, i_TX_En,
    output o_MISO, o_TX_Ready, o_RX_Byte, o_RX_En, o_RX_Count
  );

  modport master (
    output i_SPCK, i_CS_n, i_MOSI, i_TX_Byte, i_TX_En,
    input  o_MISO, o_TX_Ready, o_RX_Byte, o_RX_En, o_RX_Count
  );
endinterface

// File: rtl/spi_slave_cs.sv
// Oversampling SPI slave (all four modes) with per-CS byte counter and a
// one-deep TX holding register. Define SPI_SLAVE_MISO_HIZ_EN to float MISO while idle.
module spi_slave_cs #(
  parameter int SPI_MODE         = 0,
  parameter int MAX_BYTES_PER_CS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_slave_cs_if.slave bus
);
  localparam int             CW          = $clog2(MAX_BYTES_PER_CS + 1);
  localparam bit             CPOL        = 1'(SPI_MODE >> 1);
  localparam bit             CPHA        = 1'(SPI_MODE);
  localparam bit             SAMPLE_RISE = (CPOL == CPHA);
  localparam logic [CW-1:0]  CNT_MAX     = CW'(MAX_BYTES_PER_CS);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;

  logic spck_p0, spck_p1, spck_p2;
  logic cs_p0, cs_p1, cs_p2;
  logic mosi_p0, mosi_p1;

  logic          spck_rise, spck_fall, cs_fall, cs_rise;
  logic          sample_ev, shift_ev, cs_start, wrap, byte_start, accept;
  logic [7:0]    tx_load;
  logic [2:0]    bit_cnt;
  logic [6:0]    rx_sr;
  logic [7:0]    rx_byte;
  logic          rx_en;
  logic [CW-1:0] rx_count;
  logic [7:0]    tx_sr;
  logic [7:0]    hold;
  logic          hold_full;
  logic          miso_r;

  // Stage p0/p1: two-flop synchronizers; p2: previous value for edge detect.
  // Resetting to 0 means a CS_n still low after reset shows no falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spck_p0 <= 1'b0; spck_p1 <= 1'b0; spck_p2 <= 1'b0;
      cs_p0   <= 1'b0; cs_p1   <= 1'b0; cs_p2   <= 1'b0;
      mosi_p0 <= 1'b0; mosi_p1 <= 1'b0;
    end else begin
      spck_p0 <= bus.i_SPCK; spck_p1 <= spck_p0; spck_p2 <= spck_p1;
      cs_p0   <= bus.i_CS_n; cs_p1   <= cs_p0;   cs_p2   <= cs_p1;
      mosi_p0 <= bus.i_MOSI; mosi_p1 <= mosi_p0;
    end
  end

  assign spck_rise  = spck_p1 & ~spck_p2;
  assign spck_fall  = ~spck_p1 & spck_p2;
  assign cs_fall    = ~cs_p1 & cs_p2;
  assign cs_rise    = cs_p1 & ~cs_p2;
  assign sample_ev  = (state == ACTIVE) & (SAMPLE_RISE ? spck_rise : spck_fall);
  assign shift_ev   = (state == ACTIVE) & (SAMPLE_RISE ? spck_fall : spck_rise);
  assign cs_start   = (state == IDLE) & cs_fall;
  assign wrap       = sample_ev & (bit_cnt == 3'd7);
  assign byte_start = cs_start | wrap;
  assign tx_load    = hold_full ? hold : 8'h00;
  assign accept     = bus.i_TX_En & ~hold_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Receive path: the completed byte is registered one clk after its last sample edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= 3'd0;
      rx_sr    <= 7'd0;
      rx_byte  <= 8'h00;
      rx_en    <= 1'b0;
      rx_count <= '0;
    end else begin
      rx_en <= 1'b0;
      if (cs_start) begin
        bit_cnt  <= 3'd0;
        rx_sr    <= 7'd0;
        rx_count <= '0;
      end else if (sample_ev) begin
        rx_sr   <= {rx_sr[5:0], mosi_p1};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte <= {rx_sr, mosi_p1};
          rx_en   <= 1'b1;
          if (rx_count != CNT_MAX) rx_count <= rx_count + CW'(1);
        end
      end
    end
  end

  // Transmit path. With CPHA=0 bit 7 goes out at byte start, so the first
  // shift edge after a wrap must not advance the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr     <= 8'h00;
      miso_r    <= 1'b0;
      hold      <= 8'h00;
      hold_full <= 1'b0;
    end else begin
      if (byte_start) begin
        tx_sr <= CPHA ? tx_load : {tx_load[6:0], 1'b0};
        if (!CPHA) miso_r <= tx_load[7];
      end else if (shift_ev && (CPHA || bit_cnt != 3'd0)) begin
        miso_r <= tx_sr[7];
        tx_sr  <= {tx_sr[6:0], 1'b0};
      end
      if (accept) begin
        hold      <= bus.i_TX_Byte;
        hold_full <= 1'b1;
      end else if (byte_start) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign bus.o_TX_Ready = ~hold_full;
  assign bus.o_RX_Byte  = rx_byte;
  assign bus.o_RX_En    = rx_en;
  assign bus.o_RX_Count = rx_count;

`ifdef SPI_SLAVE_MISO_HIZ_EN
  assign bus.o_MISO = (state == ACTIVE) ? miso_r : 1'bz;
`else
  assign bus.o_MISO = (state == ACTIVE) ? miso_r : 1'b0;
`endif

endmodule
